// File: rtl/matrix_mult_ctrl_if.sv
// SRAM port bundle for the weight, input, partial-sum and output buffers,
// plus the strobes exchanged with the systolic array.
interface matrix_mult_ctrl_if #(
    parameter int W_SIZE = 512,
    parameter int I_SIZE = 512,
    parameter int O_SIZE = 512
);
    logic                      wb_mem_cenb_o;
    logic                      wb_mem_wenb_o;
    logic [$clog2(W_SIZE)-1:0] wb_mem_addr_o;
    logic                      ib_mem_cenb_o;
    logic                      ib_mem_wenb_o;
    logic [$clog2(I_SIZE)-1:0] ib_mem_addr_o;
    logic                      ps_mem_cenb_o;
    logic                      ps_mem_wenb_o;
    logic [$clog2(W_SIZE)-1:0] ps_mem_addr_o;
    logic                      ob_mem_cenb_o;
    logic                      ob_mem_wenb_o;
    logic [$clog2(O_SIZE)-1:0] ob_mem_addr_o;
    logic                      sa_weight_en_o;
    logic                      sa_valid_o;
    logic                      sa_result_valid_i;

    modport master (
        output wb_mem_cenb_o, wb_mem_wenb_o, wb_mem_addr_o,
        output ib_mem_cenb_o, ib_mem_wenb_o, ib_mem_addr_o,
        output ps_mem_cenb_o, ps_mem_wenb_o, ps_mem_addr_o,
        output ob_mem_cenb_o, ob_mem_wenb_o, ob_mem_addr_o,
        output sa_weight_en_o, sa_valid_o,
        input  sa_result_valid_i
    );

    modport slave (
        input  wb_mem_cenb_o, wb_mem_wenb_o, wb_mem_addr_o,
        input  ib_mem_cenb_o, ib_mem_wenb_o, ib_mem_addr_o,
        input  ps_mem_cenb_o, ps_mem_wenb_o, ps_mem_addr_o,
        input  ob_mem_cenb_o, ob_mem_wenb_o, ob_mem_addr_o,
        input  sa_weight_en_o, sa_valid_o,
        output sa_result_valid_i
    );
endinterface

// File: rtl/matrix_mult_ctrl.sv
// Sequencer for the ROW x COL systolic array: loads weights, streams input
// vectors (with optional partial sums) and writes results to the output buffer.
module matrix_mult_ctrl #(
    parameter int ROW    = 4,
    parameter int COL    = 4,
    parameter int W_SIZE = 512,
    parameter int I_SIZE = 512,
    parameter int O_SIZE = 512
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic                      start_i,
    input  logic                      ext_en_i,
    input  logic [$clog2(I_SIZE):0]   num_vec_i,
    input  logic [$clog2(W_SIZE)-1:0] w_base_i,
    input  logic [$clog2(I_SIZE)-1:0] i_base_i,
    input  logic [$clog2(W_SIZE)-1:0] ps_base_i,
    input  logic [$clog2(O_SIZE)-1:0] o_base_i,
    input  logic                      ps_en_i,
    matrix_mult_ctrl_if.master        mem,
    output logic                      busy_o,
    output logic                      done_o
);
    localparam int WA_W  = $clog2(W_SIZE);
    localparam int IA_W  = $clog2(I_SIZE);
    localparam int OA_W  = $clog2(O_SIZE);
    localparam int CNT_W = IA_W + 1;
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(ROW - 1);

    // The shared read counter must be able to hold ROW-1 as well as M-1.
    if (ROW < 1 || COL < 1 || ROW > I_SIZE) begin : g_bad_geometry
        $error("matrix_mult_ctrl: ROW and COL must be positive and ROW must not exceed I_SIZE");
    end

    typedef enum logic [1:0] {IDLE, LOAD_W, STREAM, DRAIN} state_t;

    state_t            state, state_nxt;
    logic              start_q;
    logic              start_pulse;
    logic              ob_wr;
    logic              drain_done;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [CNT_W-1:0]  out_cnt;

    logic [CNT_W-1:0]  num_vec_q;
    logic [WA_W-1:0]   w_base_q;
    logic [IA_W-1:0]   i_base_q;
    logic [WA_W-1:0]   ps_base_q;
    logic [OA_W-1:0]   o_base_q;
    logic              ps_en_q;

    assign start_pulse = start_i & ~start_q & ~ext_en_i & (state == IDLE);
    assign ob_wr       = mem.sa_result_valid_i & (state != IDLE) & (out_cnt < num_vec_q);
    assign drain_done  = (state == DRAIN) && (out_cnt == num_vec_q);

    assign mem.wb_mem_wenb_o = 1'b1;
    assign mem.ib_mem_wenb_o = 1'b1;
    assign mem.ps_mem_wenb_o = 1'b1;

    // Run configuration is only meaningful once a start has been accepted.
    always_ff @(posedge clk_i) begin
        if (start_pulse) begin
            num_vec_q <= num_vec_i;
            w_base_q  <= w_base_i;
            i_base_q  <= i_base_i;
            ps_base_q <= ps_base_i;
            o_base_q  <= o_base_i;
            ps_en_q   <= ps_en_i;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state              <= IDLE;
            start_q            <= 1'b0;
            cnt                <= '0;
            out_cnt            <= '0;
            mem.sa_weight_en_o <= 1'b0;
            mem.sa_valid_o     <= 1'b0;
            busy_o             <= 1'b0;
            done_o             <= 1'b1;
        end else begin
            state              <= state_nxt;
            start_q            <= start_i;
            mem.sa_weight_en_o <= (state == LOAD_W);
            mem.sa_valid_o     <= (state == STREAM);
            if (start_pulse) begin
                cnt     <= '0;
                out_cnt <= '0;
                busy_o  <= 1'b1;
                done_o  <= 1'b0;
            end else begin
                cnt <= cnt_nxt;
                if (ob_wr) out_cnt <= out_cnt + ONE;
            end
            if (drain_done) begin
                busy_o <= 1'b0;
                done_o <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt         = state;
        cnt_nxt           = cnt;
        mem.wb_mem_cenb_o = 1'b1;
        mem.wb_mem_addr_o = '0;
        mem.ib_mem_cenb_o = 1'b1;
        mem.ib_mem_addr_o = '0;
        mem.ps_mem_cenb_o = 1'b1;
        mem.ps_mem_addr_o = '0;
        mem.ob_mem_cenb_o = 1'b1;
        mem.ob_mem_wenb_o = 1'b1;
        mem.ob_mem_addr_o = '0;
        case (state)
            IDLE: begin
                if (start_pulse) state_nxt = LOAD_W;
            end
            LOAD_W: begin
                mem.wb_mem_cenb_o = 1'b0;
                mem.wb_mem_addr_o = WA_W'(w_base_q + cnt);
                if (cnt == ROW_LAST) begin
                    cnt_nxt   = '0;
                    // An empty vector list skips streaming entirely.
                    state_nxt = (num_vec_q == '0) ? DRAIN : STREAM;
                end else begin
                    cnt_nxt = cnt + ONE;
                end
            end
            STREAM: begin
                mem.ib_mem_cenb_o = 1'b0;
                mem.ib_mem_addr_o = IA_W'(i_base_q + cnt);
                if (ps_en_q) begin
                    mem.ps_mem_cenb_o = 1'b0;
                    mem.ps_mem_addr_o = WA_W'(ps_base_q + cnt);
                end
                if (cnt == num_vec_q - ONE) begin
                    cnt_nxt   = '0;
                    state_nxt = DRAIN;
                end else begin
                    cnt_nxt = cnt + ONE;
                end
            end
            DRAIN: begin
                if (drain_done) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // Result writes go straight through in the cycle the array flags them.
        if (ob_wr) begin
            mem.ob_mem_cenb_o = 1'b0;
            mem.ob_mem_wenb_o = 1'b0;
            mem.ob_mem_addr_o = OA_W'(o_base_q + out_cnt);
        end
    end
endmodule
